// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter
// Two requesters share one registered WIDTH-bit adder. A one-entry result
// register with back-pressure holds the sum, its carry and the ID of the
// winning port. Arbitration is round-robin or fixed priority (port 0 wins).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | result register empty, resp_valid = 0
// ST_FULL  | result register holds a result, resp_valid = 1

module shared_adder_arbiter #(
  parameter int WIDTH         = 32,
  parameter int PRIORITY_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             busy
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;     // port preferred on the next contended grant
  logic             slot_free;
  logic             grant;
  logic             gnt_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH:0]   sum;

  // Arbitration: pick a winner and decide whether the slot can take it.
  // rst_n gates the grant so the ready outputs read 0 during reset.
  always_comb begin
    slot_free = (state == ST_EMPTY) || resp_ready;
    grant     = rst_n && slot_free && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
      gnt_id = (PRIORITY_MODE != 0) ? 1'b0 : rr_ptr;
    end else begin
      gnt_id = req1_valid;
    end
  end

  // Single shared adder fed by the granted port's operands.
  always_comb begin
    sel_a = gnt_id ? req1_a : req0_a;
    sel_b = gnt_id ? req1_b : req0_b;
    sum   = {1'b0, sel_a} + {1'b0, sel_b};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a grant always (re)fills the slot; a drain without a grant empties it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (grant) state_nxt = ST_FULL;
      ST_FULL: begin
        if (grant) begin
          state_nxt = ST_FULL;
        end else if (resp_ready) begin
          state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Outputs: handshake readies and status. busy is held low in reset so
  // every output reads 0 while rst_n is asserted.
  always_comb begin
    resp_valid = (state == ST_FULL);
    req0_ready = grant && !gnt_id;
    req1_ready = grant && gnt_id;
    busy       = rst_n && (resp_valid || req0_valid || req1_valid);
  end

  // Result register: loaded on the granting edge, held otherwise (covers stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_result <= '0;
      resp_carry  <= 1'b0;
      resp_id     <= 1'b0;
    end else if (grant) begin
      resp_result <= sum[WIDTH-1:0];
      resp_carry  <= sum[WIDTH];
      resp_id     <= gnt_id;
    end
  end

  // Round-robin pointer: moves only on an actual grant, to the other port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (grant) begin
      rr_ptr <= ~gnt_id;
    end
  end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Self-checking bench for shared_adder_arbiter. Two instances (round-robin and
// fixed priority) share stimulus; `mode` selects which one is observed.

module tb_shared_adder_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, resp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;

  logic         rr_req0_ready, rr_req1_ready, rr_resp_valid, rr_resp_id, rr_resp_carry, rr_busy;
  logic [W-1:0] rr_resp_result;
  logic         fp_req0_ready, fp_req1_ready, fp_resp_valid, fp_resp_id, fp_resp_carry, fp_busy;
  logic [W-1:0] fp_resp_result;

  int mode = 0;

  logic         o_ready0, o_ready1, o_valid, o_id, o_carry, o_busy;
  logic [W-1:0] o_result;

  assign o_ready0 = (mode != 0) ? fp_req0_ready  : rr_req0_ready;
  assign o_ready1 = (mode != 0) ? fp_req1_ready  : rr_req1_ready;
  assign o_valid  = (mode != 0) ? fp_resp_valid  : rr_resp_valid;
  assign o_id     = (mode != 0) ? fp_resp_id     : rr_resp_id;
  assign o_carry  = (mode != 0) ? fp_resp_carry  : rr_resp_carry;
  assign o_busy   = (mode != 0) ? fp_busy        : rr_busy;
  assign o_result = (mode != 0) ? fp_resp_result : rr_resp_result;

  always #5 clk = ~clk;

  shared_adder_arbiter #(.WIDTH(W), .PRIORITY_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(rr_resp_valid), .resp_ready(resp_ready), .resp_id(rr_resp_id),
    .resp_result(rr_resp_result), .resp_carry(rr_resp_carry), .busy(rr_busy)
  );

  shared_adder_arbiter #(.WIDTH(W), .PRIORITY_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id),
    .resp_result(fp_resp_result), .resp_carry(fp_resp_carry), .busy(fp_busy)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         c;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic m_full;
  logic m_ptr;

  task automatic apply_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_full = 1'b0;
    m_ptr  = 1'b0;
    sb.delete();
  endtask

  // One clock of stimulus: drive, check readies against the model, clock,
  // then check the result register against the scoreboard.
  task automatic step(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input logic rr);
    logic       free, g, id, e0, e1, e_busy, drain;
    logic [W:0] s;
    exp_t       e;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    resp_ready = rr;
    #1;
    free = !m_full || rr;
    g    = free && (v0 || v1);
    if (v0 && v1) id = (mode != 0) ? 1'b0 : m_ptr;
    else          id = v1;
    e0     = g && !id;
    e1     = g && id;
    e_busy = m_full || v0 || v1;
    n_vec++;
    if (o_ready0 !== e0 || o_ready1 !== e1) begin
      n_err++;
      $display("FAIL ready t=%0t: got r0=%b r1=%b expected r0=%b r1=%b", $time, o_ready0, o_ready1, e0, e1);
    end
    n_vec++;
    if (o_busy !== e_busy) begin
      n_err++;
      $display("FAIL busy t=%0t: got %b expected %b", $time, o_busy, e_busy);
    end
    @(posedge clk);
    #1;
    drain = m_full && rr;
    if (drain && sb.size() > 0) void'(sb.pop_front());
    if (g) begin
      s     = {1'b0, (id ? a1 : a0)} + {1'b0, (id ? b1 : b0)};
      e.id  = id;
      e.res = s[W-1:0];
      e.c   = s[W];
      sb.push_back(e);
      m_full = 1'b1;
      m_ptr  = ~id;
    end else if (drain) begin
      m_full = 1'b0;
    end
    n_vec++;
    if (o_valid !== m_full) begin
      n_err++;
      $display("FAIL resp_valid t=%0t: got %b expected %b", $time, o_valid, m_full);
    end
    if (m_full && sb.size() > 0) begin
      n_vec++;
      if (o_id !== sb[0].id || o_result !== sb[0].res || o_carry !== sb[0].c) begin
        n_err++;
        $display("FAIL resp t=%0t: got id=%b res=%h c=%b expected id=%b res=%h c=%b",
                 $time, o_id, o_result, o_carry, sb[0].id, sb[0].res, sb[0].c);
      end
    end
  endtask

  task automatic test_reset();
    mode = 0;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    req0_a = 32'h10; req0_b = 32'h4; req1_a = 32'h10; req1_b = 32'h20;
    @(posedge clk); @(posedge clk); #1;
    n_vec++;
    if (o_valid !== 1'b0 || o_id !== 1'b0 || o_result !== '0 || o_carry !== 1'b0) begin
      n_err++;
      $display("FAIL reset_regs: got v=%b id=%b res=%h c=%b expected all 0", o_valid, o_id, o_result, o_carry);
    end
    n_vec++;
    if (o_ready0 !== 1'b0 || o_ready1 !== 1'b0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got r0=%b r1=%b busy=%b expected 0 0 0", o_ready0, o_ready1, o_busy);
    end
    rst_n = 1'b1;
    m_full = 1'b0; m_ptr = 1'b0; sb.delete();
    step(1'b1, 32'h10, 32'h4, 1'b1, 32'h10, 32'h20, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_single();
    mode = 0;
    apply_reset();
    step(1'b1, 32'h0040_0000, 32'h4, 1'b0, '0, '0, 1'b1);
    n_vec++;
    if (o_result !== 32'h0040_0004 || o_id !== 1'b0 || o_carry !== 1'b0) begin
      n_err++;
      $display("FAIL single_abs: got id=%b res=%h c=%b expected id=0 res=00400004 c=0", o_id, o_result, o_carry);
    end
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_round_robin();
    mode = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h10, 32'h4, 1'b1, 32'h10, 32'h20, 1'b1);
      n_vec++;
      if (o_id !== logic'(i % 2) || o_result !== ((i % 2) ? 32'h30 : 32'h14)) begin
        n_err++;
        $display("FAIL rr_seq[%0d]: got id=%b res=%h expected id=%0d", i, o_id, o_result, i % 2);
      end
    end
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_fixed_priority();
    mode = 1;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h10, 32'h4, 1'b1, 32'h10, 32'h20, 1'b1);
    end
    step(1'b0, '0, '0, 1'b1, 32'h10, 32'h20, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    mode = 0;
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] held;
    mode = 0;
    apply_reset();
    step(1'b1, 32'h100, 32'h1, 1'b0, '0, '0, 1'b1);
    held = o_result;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h200, 32'h2, 1'b1, 32'h300, 32'h3, 1'b0);
      n_vec++;
      if (o_result !== 32'h101 || o_id !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got id=%b res=%h expected id=0 res=00000101", i, o_id, o_result);
      end
    end
    step(1'b1, 32'h200, 32'h2, 1'b1, 32'h300, 32'h3, 1'b1);
    n_vec++;
    if (o_valid !== 1'b1 || o_result === held) begin
      n_err++;
      $display("FAIL drain_grant: got v=%b res=%h expected v=1 and new result", o_valid, o_result);
    end
    step(1'b1, 32'h200, 32'h2, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_wrap_reset();
    mode = 0;
    apply_reset();
    step(1'b0, '0, '0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    n_vec++;
    if (o_result !== 32'h0 || o_carry !== 1'b1 || o_id !== 1'b1) begin
      n_err++;
      $display("FAIL wrap: got id=%b res=%h c=%b expected id=1 res=00000000 c=1", o_id, o_result, o_carry);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_valid !== 1'b0 || o_id !== 1'b0 || o_carry !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b id=%b c=%b expected 0 0 0", o_valid, o_id, o_carry);
    end
    @(posedge clk); #1;
    apply_reset();
    step(1'b1, 32'h7, 32'h8, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_back_pressure();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shared_adder_arbiter.md
Name: shared_adder_arbiter

Overview:
- Shares one registered WIDTH-bit adder between two requesters, e.g. PC+4 incrementer (port 0) and branch-target adder (port 1), so the datapath needs a single adder instance.
- Each requester has a valid/ready handshake.
- One-entry result register with back-pressure.
- Round-robin or fixed-priority arbitration; results carry the ID of the winning port.

Parameters:
WIDTH, 32, operand/result width in bits
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 always wins)

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Req0Valid  input  1  port 0 has operands
Req0Ready  output  1  port 0 accepted this cycle
Req0A  input  WIDTH  port 0 operand A
Req0B  input  WIDTH  port 0 operand B
Req1Valid  input  1  port 1 has operands
Req1Ready  output  1  port 1 accepted this cycle
Req1A  input  WIDTH  port 1 operand A
Req1B  input  WIDTH  port 1 operand B
RespValid  output  1  result register holds a valid result
RespReady  input  1  consumer takes result this cycle
RespId  output  1  port that produced result (0/1)
RespResult  output  WIDTH  (A+B) mod 2^WIDTH
RespCarry  output  1  carry out of bit WIDTH-1
Busy  output  1  RespValid OR any ReqNValid

Behaviour:
- Reset low (async): RespValid=0, RespId=0, RespResult=0, RespCarry=0, round-robin pointer=port 0 preferred. Any pending result is discarded. Ready outputs are combinational and read 0 while Reset low.
- FSM, 2 states:
  - EMPTY: RespValid=0.
  - FULL: RespValid=1.
  - EMPTY->FULL on a grant.
  - FULL->FULL on grant with drain (RespReady=1) or on stall.
  - FULL->EMPTY on drain with no grant.
- Grant condition: slot free = EMPTY OR (FULL AND RespReady). No grant otherwise.
- ReqNReady is combinational: high only for the granted port, and only when slot free and ReqNValid=1. At most one Ready high per cycle.
- Handshake:
  - Transfer on ReqNValid AND ReqNReady at rising Clk.
  - Requesters hold Valid/A/B stable until accepted. Arbiter does not require this, but only sampled values matter.
- Arbitration with both valid:
  - PRIORITY_MODE=1: port 0 wins.
  - PRIORITY_MODE=0: port opposite the last granted port wins. Pointer updates only on an actual grant. A lone valid port is always granted if slot free.
- Datapath: at the granting edge, RespResult<=A+B (WIDTH bits), RespCarry<=bit WIDTH of the WIDTH+1-bit sum, RespId<=granted port.
- Latency 1 cycle: accepted at edge N, RespValid=1 after edge N.
- Throughput: 1 result/cycle while RespReady=1.
- Stall: RespValid=1 with RespReady=0 holds RespResult/RespId/RespCarry stable, and both Ready=0.
- Simultaneous drain and grant in one cycle: old result consumed, new result loaded same edge, RespValid stays 1.
- Wrap-around: 0xFFFFFFFF+0x00000001 gives Result=0x00000000, Carry=1. No saturation.
- Starvation bound (round-robin): a continuously valid port is granted within 2 grant opportunities.

Test Plan:
- Reset/idle: hold Reset=0 with both Valid=1 -> all outputs 0, both Ready=0. Release Reset -> first edge grants port 0.
- Single port: Req0 A=0x00400000, B=4, RespReady=1 -> next cycle RespValid=1, Id=0, Result=0x00400004, Carry=0.
- Round-robin contention, mode 0: both valid continuously (port0 A=0x10,B=4; port1 A=0x10,B=0x20), RespReady=1 -> Ids 0,1,0,1…, Results 0x14,0x30 alternating, one per cycle.
- Fixed priority, mode 1: same stimulus -> Id=0 every cycle, Req1Ready never high.
- Back-pressure: RespReady=0 for 3 cycles after a result -> result and Id stable, Ready=0. RespReady=1 -> drain and new grant on the same edge, RespValid stays 1.
- Wrap and reset mid-op: Req1 A=0xFFFFFFFF, B=1 -> Result=0, Carry=1, Id=1. Assert Reset while RespValid=1 -> RespValid=0 immediately, without waiting for a clock edge.
